// File: rtl/johnson_pkg.sv
// Shared types and decode helpers for the Johnson counter family.
// Functions take a maximum-width vector plus the live ring width so one body serves every WIDTH.
package johnson_pkg;

  localparam int JW_MAX = 64;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // A legal twisted-ring code has at most one boundary between a run of ones and a run of zeros.
  function automatic logic johnson_valid(input logic [JW_MAX-1:0] q, input int width);
    int unsigned diffs;
    diffs = 0;
    for (int i = 0; i < JW_MAX - 1; i++) begin
      if ((i < width - 1) && (q[i] != q[i+1])) diffs++;
    end
    return (diffs <= 1);
  endfunction

  function automatic int unsigned johnson_idx(input logic [JW_MAX-1:0] q, input int width);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < JW_MAX; i++) begin
      if ((i < width) && q[i]) ones++;
    end
    if (!johnson_valid(q, width)) return 0;
    if (!q[width-1]) return ones;
    return unsigned'(width) + (unsigned'(width) - ones);
  endfunction

endpackage

// File: rtl/johnson_ctr_if.sv
// Bundle of the counter's control and status signals, for benches and wrappers
// that want to pass the whole group around as one port.
interface johnson_ctr_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2*WIDTH)
) ();
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic             illegal;
  logic             rst_short;

  modport master (
    output en, dir, load, load_val,
    input  q, idx, wrap, illegal, rst_short
  );

  modport slave (
    input  en, dir, load, load_val,
    output q, idx, wrap, illegal, rst_short
  );
endinterface

// File: rtl/rst_len_mon.sv
// Reset-length monitor: flags (sticky) any reset pulse shorter than MIN_RST_CYCLES.
// Deliberately not cleared by the reset it watches.
module rst_len_mon #(
  parameter int MIN_RST_CYCLES = 4,
  parameter bit SVA_EN         = 1'b1
) (
  input  logic i_clk,
  input  logic i_srst,
  output logic o_rst_short
);

  localparam int CNT_W = $clog2(MIN_RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_RST_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             srst_q;
  logic             short_q, short_d;

  always_comb begin
    cnt_d   = cnt_q;
    short_d = short_q;
    if (!i_srst) begin
      cnt_d = '0;
    end else if (cnt_q != MIN_CNT) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Falling edge of reset with too few high cycles sets the flag; a full-length pulse clears it.
    if (!i_srst && srst_q && (cnt_q < MIN_CNT)) begin
      short_d = 1'b1;
    end else if (i_srst && (cnt_d == MIN_CNT)) begin
      short_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    cnt_q   <= cnt_d;
    srst_q  <= i_srst;
    short_q <= short_d;
  end

  assign o_rst_short = short_q;

`ifndef SYNTHESIS
  generate
    if (SVA_EN) begin : g_sva
      a_min_rst_len: assert property (@(posedge i_clk) (srst_q && !i_srst) |-> (cnt_q >= MIN_CNT))
        else $error("rst_len_mon: reset pulse of %0d cycles is shorter than MIN_RST_CYCLES=%0d",
                    cnt_q, MIN_RST_CYCLES);
    end
  endgenerate
`endif

endmodule

// File: rtl/johnson_ctr.sv
// Parametrised Johnson counter with direction, raw load, illegal-code self-correction,
// registered wrap pulse and an attached reset-length monitor.
module johnson_ctr
  import johnson_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int MIN_RST_CYCLES = 4,
  parameter bit RST_SVA_EN     = 1'b1,
  parameter int IDX_W          = $clog2(2*WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_wrap,
  output logic             o_illegal,
  output logic             o_rst_short
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             illegal;
  logic [IDX_W-1:0] idx;

  assign illegal = !johnson_valid(JW_MAX'(q_q), WIDTH);
  assign idx     = IDX_W'(johnson_idx(JW_MAX'(q_q), WIDTH));

  // Wrap is only ever raised by a genuine step, so reset, load and correction all leave it low.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (i_srst) begin
      q_d = '0;
    end else if (i_load) begin
      q_d = i_load_val;
    end else if (i_en && illegal) begin
      q_d = '0;
    end else if (i_en) begin
      if (dir_e'(i_dir) == DIR_FWD) begin
        q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        wrap_d = (idx == LAST_IDX);
      end else begin
        q_d    = {~q_q[0], q_q[WIDTH-1:1]};
        wrap_d = (idx == '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  rst_len_mon #(
    .MIN_RST_CYCLES (MIN_RST_CYCLES),
    .SVA_EN         (RST_SVA_EN)
  ) u_mon (
    .i_clk       (i_clk),
    .i_srst      (i_srst),
    .o_rst_short (o_rst_short)
  );

  assign o_q       = q_q;
  assign o_idx     = idx;
  assign o_wrap    = wrap_q;
  assign o_illegal = illegal;

endmodule

// File: tb/tb_johnson_ctr.sv
// Directed, table-driven bench for johnson_ctr: a WIDTH=4 instance driven from a vector
// table, and a WIDTH=5 / MIN_RST_CYCLES=1 instance driven by hand-written sequences.
module tb_johnson_ctr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst4;
  logic srst5;

  johnson_ctr_if #(.WIDTH(4)) if4 ();
  johnson_ctr_if #(.WIDTH(5)) if5 ();

  // Short resets are applied on purpose here, so the monitor assertion is left off.
  johnson_ctr #(
    .WIDTH(4), .MIN_RST_CYCLES(4), .RST_SVA_EN(1'b0)
  ) dut4 (
    .i_clk(clk), .i_srst(srst4), .i_en(if4.en), .i_dir(if4.dir), .i_load(if4.load),
    .i_load_val(if4.load_val), .o_q(if4.q), .o_idx(if4.idx), .o_wrap(if4.wrap),
    .o_illegal(if4.illegal), .o_rst_short(if4.rst_short)
  );

  johnson_ctr #(
    .WIDTH(5), .MIN_RST_CYCLES(1)
  ) dut5 (
    .i_clk(clk), .i_srst(srst5), .i_en(if5.en), .i_dir(if5.dir), .i_load(if5.load),
    .i_load_val(if5.load_val), .o_q(if5.q), .o_idx(if5.idx), .o_wrap(if5.wrap),
    .o_illegal(if5.illegal), .o_rst_short(if5.rst_short)
  );

  typedef struct {
    logic       srst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_q;
    logic [2:0] exp_idx;
    logic       exp_wrap;
    logic       exp_ill;
    logic       chk_short;
    logic       exp_short;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic e, input logic d, input logic l,
                              input logic [3:0] lv, input logic [3:0] q, input logic [2:0] idx,
                              input logic w, input logic ill, input logic cs, input logic sh);
    vec_t v;
    v.srst = s; v.en = e; v.dir = d; v.load = l; v.load_val = lv;
    v.exp_q = q; v.exp_idx = idx; v.exp_wrap = w; v.exp_ill = ill;
    v.chk_short = cs; v.exp_short = sh;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] pat5 [10];
  int         wraps;
  int         k;

  initial begin
    srst4 = 1'b1; if4.en = 1'b0; if4.dir = 1'b0; if4.load = 1'b0; if4.load_val = '0;
    srst5 = 1'b1; if5.en = 1'b0; if5.dir = 1'b0; if5.load = 1'b0; if5.load_val = '0;

    // ---- WIDTH=4 vector table: {srst,en,dir,load,load_val} -> {q,idx,wrap,illegal,[short]}
    for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 0,0);
    add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h1,3'd1,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h3,3'd2,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h7,3'd3,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'hF,3'd4,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'hE,3'd5,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'hC,3'd6,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h8,3'd7,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h0,3'd0,1,0, 1,0);
    add(0,1,1,0,4'h0, 4'h8,3'd7,1,0, 1,0);
    add(0,1,1,0,4'h0, 4'hC,3'd6,0,0, 1,0);
    add(0,0,1,0,4'h0, 4'hC,3'd6,0,0, 1,0);
    add(0,0,0,0,4'h0, 4'hC,3'd6,0,0, 1,0);
    add(0,0,0,1,4'h5, 4'h5,3'd0,0,1, 1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,4'h0, 4'h5,3'd0,0,1, 1,0);
    add(0,1,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,0,0,1,4'hC, 4'hC,3'd6,0,0, 1,0);
    add(0,1,0,1,4'h3, 4'h3,3'd2,0,0, 1,0);
    add(0,0,0,1,4'hC, 4'hC,3'd6,0,0, 1,0);
    add(1,1,0,1,4'h3, 4'h0,3'd0,0,0, 1,0);
    add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,1);
    add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,1,0,0,4'h0, 4'h1,3'd1,0,0, 1,0);
    add(0,1,1,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,1,1,0,4'h0, 4'h8,3'd7,1,0, 1,0);
    add(0,1,0,0,4'h0, 4'h0,3'd0,1,0, 1,0);
    add(0,0,0,1,4'h9, 4'h9,3'd0,0,1, 1,0);
    add(0,1,1,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,1,1,0,4'h0, 4'h8,3'd7,1,0, 1,0);
    add(1,1,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);
    add(0,0,0,0,4'h0, 4'h0,3'd0,0,0, 1,0);

    for (int r = 0; r < vecs.size(); r++) begin
      srst4 = vecs[r].srst; if4.en = vecs[r].en; if4.dir = vecs[r].dir;
      if4.load = vecs[r].load; if4.load_val = vecs[r].load_val;
      tick();
      $display("w4 row %0d: srst=%b en=%b dir=%b load=%b val=%h -> q=%b idx=%0d wrap=%b ill=%b short=%b",
               r, vecs[r].srst, vecs[r].en, vecs[r].dir, vecs[r].load, vecs[r].load_val,
               if4.q, if4.idx, if4.wrap, if4.illegal, if4.rst_short);
      chk("w4_q",       r, 32'(if4.q),       32'(vecs[r].exp_q));
      chk("w4_idx",     r, 32'(if4.idx),     32'(vecs[r].exp_idx));
      chk("w4_wrap",    r, 32'(if4.wrap),    32'(vecs[r].exp_wrap));
      chk("w4_illegal", r, 32'(if4.illegal), 32'(vecs[r].exp_ill));
      if (vecs[r].chk_short) chk("w4_rst_short", r, 32'(if4.rst_short), 32'(vecs[r].exp_short));
    end
    srst4 = 1'b0; if4.en = 1'b0; if4.load = 1'b0;

    // ---- WIDTH=5, MIN_RST_CYCLES=1: full 10-state forward ring, twice around
    pat5[0] = 5'b00000; pat5[1] = 5'b00001; pat5[2] = 5'b00011; pat5[3] = 5'b00111;
    pat5[4] = 5'b01111; pat5[5] = 5'b11111; pat5[6] = 5'b11110; pat5[7] = 5'b11100;
    pat5[8] = 5'b11000; pat5[9] = 5'b10000;

    chk("w5_reset_q", 0, 32'(if5.q), 32'h0);
    chk("w5_reset_short", 0, 32'(if5.rst_short), 32'h0);
    srst5 = 1'b0; if5.en = 1'b1; if5.dir = 1'b0;
    wraps = 0;
    for (k = 1; k <= 20; k++) begin
      tick();
      $display("w5 step %0d: q=%b idx=%0d wrap=%b", k, if5.q, if5.idx, if5.wrap);
      chk("w5_q",       k, 32'(if5.q),       32'(pat5[k % 10]));
      chk("w5_idx",     k, 32'(if5.idx),     32'(k % 10));
      chk("w5_wrap",    k, 32'(if5.wrap),    32'((k % 10) == 0));
      chk("w5_illegal", k, 32'(if5.illegal), 32'h0);
      if (if5.wrap) wraps++;
    end
    chk("w5_wrap_count", 20, 32'(wraps), 32'd2);

    // reverse wrap 0 -> 9
    if5.dir = 1'b1;
    tick();
    $display("w5 rev: q=%b idx=%0d wrap=%b", if5.q, if5.idx, if5.wrap);
    chk("w5_rev_q",    21, 32'(if5.q),    32'(pat5[9]));
    chk("w5_rev_idx",  21, 32'(if5.idx),  32'd9);
    chk("w5_rev_wrap", 21, 32'(if5.wrap), 32'h1);

    // one-cycle reset mid-sequence is legal here: flag stays low
    srst5 = 1'b1;
    tick();
    $display("w5 srst: q=%b wrap=%b short=%b", if5.q, if5.wrap, if5.rst_short);
    chk("w5_srst_q",     22, 32'(if5.q),         32'h0);
    chk("w5_srst_wrap",  22, 32'(if5.wrap),      32'h0);
    chk("w5_srst_short", 22, 32'(if5.rst_short), 32'h0);
    srst5 = 1'b0; if5.en = 1'b0;
    tick();
    $display("w5 release: q=%b short=%b", if5.q, if5.rst_short);
    chk("w5_rel_q",     23, 32'(if5.q),         32'h0);
    chk("w5_rel_short", 23, 32'(if5.rst_short), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/johnson_ctr.md
# johnson_ctr

Parametrised synchronous Johnson (twisted-ring) counter with enable, direction control, raw-pattern load, illegal-code detection with self-correction, and an integrated reset-length monitor. It is the next generation of the team's fixed 4-bit Johnson sequencer. It serves as a phase generator for multi-phase enables and strobes. The monitor flags any reset pulse shorter than a configurable minimum.

## Interface
- `WIDTH`, default 4: ring length in bits, ≥2. The sequence has 2·WIDTH states.
- `MIN_RST_CYCLES`, default 4: minimum legal reset pulse length in cycles, ≥1.
- `IDX_W`, default `$clog2(2*WIDTH)`: derived index width. Not to be overridden.

Ports:
- `i_clk`, in, 1: single clock, rising edge.
- `i_srst`, in, 1: synchronous, active-high reset.
- `i_en`, in, 1: advance one state this cycle.
- `i_dir`, in, 1: 0 = forward, 1 = reverse.
- `i_load`, in, 1: load `i_load_val` into the ring.
- `i_load_val`, in, WIDTH: raw pattern to load. May be illegal.
- `o_q`, out, WIDTH: ring register.
- `o_idx`, out, IDX_W: state index 0..2·WIDTH-1, decoded combinationally from `o_q`.
- `o_wrap`, out, 1: registered one-cycle pulse on a sequence wrap.
- `o_illegal`, out, 1: `o_q` is not a valid Johnson code (combinational from `o_q`).
- `o_rst_short`, out, 1: sticky flag, last reset pulse was shorter than MIN_RST_CYCLES.

## Operation
- Forward step: `o_q <= {o_q[W-2:0], ~o_q[W-1]}`.
- Reverse step: `o_q <= {~o_q[0], o_q[W-1:1]}`.
- Valid code: at most one adjacent-bit difference across `o_q[W-1:0]`.
- `o_idx` decode:
  - If `o_q[W-1]==0`: index = popcount(`o_q`).
  - Else: index = WIDTH + count of zeros in `o_q`.
  - Forced to 0 while `o_illegal`.
- Next-state priority per edge:
  1. `i_srst`: `o_q`=0.
  2. `i_load`: `o_q`=`i_load_val`.
  3. `i_en` while `o_illegal`: `o_q`=0 (self-correct, no shift).
  4. `i_en`: step in direction `i_dir`.
  5. Otherwise hold.
- `o_wrap` is set on an edge whose step moves index 2W-1→0 (forward) or 0→2W-1 (reverse). It is high exactly the cycle `o_q` holds the new state and 0 otherwise. It is never set by load, by correction, or during reset.
- `i_dir` may change on any cycle. The step uses the value sampled at that edge.
- Reset monitor:
  - `rst_cnt` counts consecutive `i_srst`-high cycles, saturating at MIN_RST_CYCLES. It is cleared on any `i_srst`-low cycle.
  - When `i_srst` falls and the count is below MIN_RST_CYCLES, `o_rst_short` is set on that edge (the first low cycle).
  - `o_rst_short` is cleared on the edge where `rst_cnt` reaches MIN_RST_CYCLES.
  - Monitor registers are not reset by `i_srst`. They are undefined until the first reset of ≥MIN_RST_CYCLES, or the first low `i_srst` for `rst_cnt`.
- Simulation-only SVA (synthesis off): after `i_srst` falls, it must have been high for at least MIN_RST_CYCLES cycles. A failure fires `$error` with a message naming MIN_RST_CYCLES.

## Timing
- Reset values: `o_q`=0, `o_idx`=0, `o_wrap`=0, `o_illegal`=0. `o_rst_short`=0 once reset has been held MIN_RST_CYCLES cycles.
- State latency is 1 cycle from `i_en`/`i_load` to `o_q`. `o_idx` and `o_illegal` are valid in the same cycle as `o_q`.
- Reset mid-sequence: `o_q`=0 next edge, any pending wrap is suppressed, and load/enable are ignored.
- Load and enable together: the load wins and the step is dropped.
- Illegal load: `o_illegal` is high the cycle after the load. It is cleared one edge after the next `i_en`. The held value is kept indefinitely while `i_en`=0.
- WIDTH where 2·WIDTH is not a power of two: `o_idx` never exceeds 2W-1.

## Structure
- Package `johnson_pkg` holds:
  - `typedef enum logic {DIR_FWD=0, DIR_REV=1} dir_e`.
  - Functions `johnson_valid(q)` and `johnson_idx(q)`, parametrised via a WIDTH argument or a parametrised class.
- One sub-module `rst_len_mon`, parameter MIN_RST_CYCLES. It takes `i_clk` and `i_srst` and drives `o_rst_short`. It holds the saturating counter, the delayed `i_srst`, and the SVA.
- The top level holds the ring register, next-state priority mux, wrap logic, and the decode calls.

## Test plan
- Reset 4 cycles, then `i_en`=1, `i_dir`=0, WIDTH=4: `o_q` goes 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with `o_idx` 1..7, 0. `o_wrap`=1 only on the 0000 cycle.
- From 0000 with `i_dir`=1: 1000 (`o_idx`=7, `o_wrap`=1), then 1100 (`o_idx`=6). Toggling `i_en`=0 holds `o_q` with `o_wrap`=0.
- `i_load`=1 with 0101: next cycle `o_illegal`=1, `o_idx`=0. Hold 3 cycles with `i_en`=0, unchanged. Then `i_en`=1 gives 0000, `o_illegal`=0, no wrap.
- `i_load`=1 and `i_en`=1 with 0011 at idx 6: `o_q`=0011, `o_idx`=2. Same with `i_srst`=1: `o_q`=0000.
- `i_srst` high 2 cycles: `o_rst_short`=1 on the first low cycle and the SVA fires. Then `i_srst` high 4 cycles: `o_rst_short`=0 on the 4th high edge and stays 0 after release.
- WIDTH=5, MIN_RST_CYCLES=1: a full forward cycle of 10 states, `o_idx` 0..9, one wrap per 10 enables. A 1-cycle reset leaves `o_rst_short`=0.
